// File: rtl/spi_master_module_if.sv
// Word-side bus of spi_master_module: 4-bit tx handshake plus the captured ack byte.
// The master modport is the word source; the slave modport is the SPI master block itself.
interface spi_master_module_if;
    logic [3:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       ack_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, rx_byte, rx_valid, ack_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, rx_byte, rx_valid, ack_err
    );
endinterface

// File: rtl/spi_master_module.sv
// SPI mode-0 master: frames a 4-bit word (zero padded to FRAME_BITS) and captures an 8-bit ack.
// Define SPI_MASTER_ACK_CHECK_EN to flag ack bytes that differ from EXPECTED_ACK on ack_err.
module spi_master_module #(
    parameter int unsigned CLK_DIV      = 8,
    parameter int unsigned SS_SETUP     = 4,
    parameter int unsigned FRAME_BITS   = 8,
    parameter int unsigned IDLE_GAP     = 8,
    parameter logic [7:0]  EXPECTED_ACK = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    spi_master_module_if.slave bus,
    input  logic               miso_in,
    output logic               sclk_out,
    output logic               mosi_out,
    output logic               ss_n_out
);

    typedef enum logic [2:0] {StIdle, StSetup, StLow, StHigh, StHold, StGap} state_e;

    localparam logic [7:0] DivLast   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SetupLast = 8'(SS_SETUP - 1);
    localparam logic [7:0] GapLast   = 8'(IDLE_GAP - 1);
    localparam logic [4:0] BitsTotal = 5'(FRAME_BITS);

    state_e      state;
    logic [7:0]  cnt;
    logic [4:0]  bit_cnt;
    logic [4:0]  bit_cnt_nxt;
    logic [15:0] tx_sr;
    logic [7:0]  rx_sr;
    logic        miso_s1;
    logic        miso_s2;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  rx_byte;
    logic        rx_valid;
`ifdef SPI_MASTER_ACK_CHECK_EN
    logic        ack_err;
`endif

    assign bit_cnt_nxt = bit_cnt + 5'd1;

    always_ff @(posedge clk) begin
        miso_s1 <= miso_in;
        miso_s2 <= miso_s1;
        if (reset) begin
            state    <= StIdle;
            cnt      <= 8'd0;
            bit_cnt  <= 5'd0;
            tx_sr    <= 16'h0000;
            rx_sr    <= 8'h00;
            ss_n_out <= 1'b1;
            sclk_out <= 1'b0;
            mosi_out <= 1'b0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            rx_byte  <= 8'h00;
            rx_valid <= 1'b0;
`ifdef SPI_MASTER_ACK_CHECK_EN
            ack_err  <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef SPI_MASTER_ACK_CHECK_EN
            ack_err  <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    if (bus.tx_valid && tx_ready) begin
                        // Word sits MSB-aligned; bits past the nibble shift out as zeros.
                        tx_sr    <= {bus.tx_data, 12'h000};
                        mosi_out <= bus.tx_data[3];
                        rx_sr    <= 8'h00;
                        bit_cnt  <= 5'd0;
                        cnt      <= 8'd0;
                        ss_n_out <= 1'b0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt == SetupLast) begin
                        cnt   <= 8'd0;
                        state <= StLow;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StLow: begin
                    if (cnt == DivLast) begin
                        cnt <= 8'd0;
                        if (bit_cnt < 5'd8) begin
                            rx_sr <= {rx_sr[6:0], miso_s2};
                        end
                        sclk_out <= 1'b1;
                        state    <= StHigh;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StHigh: begin
                    if (cnt == DivLast) begin
                        cnt      <= 8'd0;
                        sclk_out <= 1'b0;
                        bit_cnt  <= bit_cnt_nxt;
                        if (bit_cnt_nxt == BitsTotal) begin
                            state <= StHold;
                        end else begin
                            tx_sr    <= tx_sr << 1;
                            mosi_out <= tx_sr[14];
                            state    <= StLow;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StHold: begin
                    if (cnt == DivLast) begin
                        cnt      <= 8'd0;
                        ss_n_out <= 1'b1;
                        mosi_out <= 1'b0;
                        rx_byte  <= rx_sr;
                        rx_valid <= 1'b1;
`ifdef SPI_MASTER_ACK_CHECK_EN
                        ack_err  <= (rx_sr != EXPECTED_ACK);
`endif
                        state    <= StGap;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StGap: begin
                    if (cnt == GapLast) begin
                        cnt      <= 8'd0;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= StIdle;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.tx_ready = tx_ready;
    assign bus.busy     = busy;
    assign bus.rx_byte  = rx_byte;
    assign bus.rx_valid = rx_valid;
`ifdef SPI_MASTER_ACK_CHECK_EN
    assign bus.ack_err  = ack_err;
`else
    assign bus.ack_err  = 1'b0;
    logic unused_ack;
    assign unused_ack = ^EXPECTED_ACK;
`endif

endmodule

// File: tb/tb_spi_master_module.sv
// Directed bench for spi_master_module with default parameters and a behavioural mode-0 slave.
module tb_spi_master_module;

`ifdef SPI_MASTER_ACK_CHECK_EN
    localparam int AckEn = 1;
`else
    localparam int AckEn = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic miso = 1'b0;
    logic sclk_out, mosi_out, ss_n_out;

    spi_master_module_if bus ();

    spi_master_module dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .miso_in  (miso),
        .sclk_out (sclk_out),
        .mosi_out (mosi_out),
        .ss_n_out (ss_n_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / slave-model state, sampled on the falling clk edge.
    logic [7:0] miso_pat = 8'h00;
    int         miso_idx = -1;
    logic       prev_ss = 1'b1, prev_sclk = 1'b0, prev_ready = 1'b1;
    int t_accept, t_ssfall, t_ssrise, t_first_rise, t_prev_rise, t_last_fall, t_ready_back;
    int period, rise_cnt, n_accept, n_ssfall, valid_cnt, ackerr_cnt, ack_with_valid;
    logic [7:0] mosi_bits, rx_seen;

    always @(negedge clk) begin
        if (bus.tx_valid && bus.tx_ready && !reset) begin
            t_accept = cyc;
            n_accept++;
        end
        if (prev_ss && !ss_n_out) begin
            t_ssfall  = cyc;
            n_ssfall++;
            rise_cnt  = 0;
            mosi_bits = 8'h00;
            miso      = miso_pat[7];
            miso_idx  = 6;
        end
        if (!prev_ss && ss_n_out) t_ssrise = cyc;
        if (!prev_sclk && sclk_out) begin
            if (rise_cnt == 0) t_first_rise = cyc;
            else period = cyc - t_prev_rise;
            t_prev_rise = cyc;
            if (rise_cnt < 8) mosi_bits = {mosi_bits[6:0], mosi_out};
            rise_cnt++;
        end
        if (prev_sclk && !sclk_out) begin
            t_last_fall = cyc;
            if (miso_idx >= 0) begin
                miso = miso_pat[miso_idx];
                miso_idx--;
            end else begin
                miso = 1'b0;
            end
        end
        if (!prev_ready && bus.tx_ready) t_ready_back = cyc;
        if (bus.rx_valid) begin
            valid_cnt++;
            rx_seen = bus.rx_byte;
            if (bus.ack_err) ack_with_valid++;
        end
        if (bus.ack_err) ackerr_cnt++;
        prev_ss    = ss_n_out;
        prev_sclk  = sclk_out;
        prev_ready = bus.tx_ready;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_accept = 0;
        n_ssfall = 0;
        valid_cnt = 0;
        ackerr_cnt = 0;
        ack_with_valid = 0;
        rx_seen = 8'h00;
        period = 0;
    endtask

    task automatic send(input logic [3:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(bus.tx_ready && !bus.busy) && n < 400) begin
            tick();
            n++;
        end
        check_val(tag, 32'(n < 400), 32'd1);
        tick();
    endtask

    initial begin
        int gap_busy, ready_cyc, n;
        bus.tx_data  = 4'h0;
        bus.tx_valid = 1'b0;
        clear_mon();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check_val("rst_ss_n", 32'(ss_n_out), 32'd1);
        check_val("rst_sclk", 32'(sclk_out), 32'd0);
        check_val("rst_mosi", 32'(mosi_out), 32'd0);
        check_val("rst_ready", 32'(bus.tx_ready), 32'd1);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_rx_byte", 32'(bus.rx_byte), 32'h00);
        check_val("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_val("rst_ack_err", 32'(bus.ack_err), 32'd0);

        // Frame timing with 4'hA; slave returns 8'hC5 to prove MSB-first capture
        clear_mon();
        miso_pat = 8'hC5;
        send(4'hA);
        wait_idle("a_timeout");
        check_val("a_ss_fall", 32'(t_ssfall - t_accept), 32'd1);
        check_val("a_first_rise", 32'(t_first_rise - t_ssfall), 32'd12);
        check_val("a_pulses", 32'(rise_cnt), 32'd8);
        check_val("a_mosi", 32'(mosi_bits), 32'hA0);
        check_val("a_period", 32'(period), 32'd16);
        check_val("a_hold", 32'(t_ssrise - t_last_fall), 32'd8);
        check_val("a_frame_len", 32'(t_ready_back - t_accept), 32'd149);
        check_val("a_valid_cnt", 32'(valid_cnt), 32'd1);
        check_val("a_rx_byte", 32'(rx_seen), 32'hC5);
        check_val("a_ack_err", 32'(ack_with_valid), 32'(AckEn));

        // Loopback-style exchange: slave sees nibble 5, answers 8'h00
        clear_mon();
        miso_pat = 8'h00;
        send(4'h5);
        wait_idle("l_timeout");
        check_val("l_slave_nibble", 32'(mosi_bits[7:4]), 32'h5);
        check_val("l_mosi", 32'(mosi_bits), 32'h50);
        check_val("l_rx_byte", 32'(rx_seen), 32'h00);
        check_val("l_valid_cnt", 32'(valid_cnt), 32'd1);
        check_val("l_ack_err", 32'(ackerr_cnt), 32'd0);

        // MISO stuck high
        clear_mon();
        miso_pat = 8'hFF;
        send(4'h0);
        wait_idle("f_timeout");
        check_val("f_rx_byte", 32'(rx_seen), 32'hFF);
        check_val("f_valid_cnt", 32'(valid_cnt), 32'd1);
        check_val("f_ack_with_valid", 32'(ack_with_valid), 32'(AckEn));
        check_val("f_ack_total", 32'(ackerr_cnt), 32'(AckEn));

        // Back-to-back with tx_valid held high
        clear_mon();
        miso_pat = 8'h00;
        bus.tx_data  = 4'h3;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_data = 4'hC;
        n = 0;
        while (!(ss_n_out && bus.busy) && n < 400) begin
            tick();
            n++;
        end
        check_val("b_first_end", 32'(n < 400), 32'd1);
        gap_busy = 0;
        ready_cyc = 0;
        n = 0;
        while (n_ssfall < 2 && n < 100) begin
            if (ss_n_out && bus.busy) gap_busy++;
            if (bus.tx_ready) ready_cyc++;
            tick();
            n++;
        end
        bus.tx_valid = 1'b0;
        check_val("b_second_start", 32'(n < 100), 32'd1);
        check_val("b_gap_cycles", 32'(gap_busy), 32'd8);
        check_val("b_ready_cycles", 32'(ready_cyc), 32'd1);
        wait_idle("b_timeout");
        check_val("b_mosi2", 32'(mosi_bits), 32'hC0);
        check_val("b_accepts", 32'(n_accept), 32'd2);
        check_val("b_valid_cnt", 32'(valid_cnt), 32'd2);

        // Reset 40 cycles into a frame
        clear_mon();
        send(4'hF);
        repeat (39) tick();
        reset = 1'b1;
        tick();
        check_val("r_ss_n", 32'(ss_n_out), 32'd1);
        check_val("r_sclk", 32'(sclk_out), 32'd0);
        check_val("r_ready", 32'(bus.tx_ready), 32'd1);
        check_val("r_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        repeat (20) tick();
        check_val("r_no_valid", 32'(valid_cnt), 32'd0);
        check_val("r_no_ack_err", 32'(ackerr_cnt), 32'd0);
        miso_pat = 8'h3C;
        send(4'h6);
        wait_idle("r_timeout");
        check_val("r_mosi", 32'(mosi_bits), 32'h60);
        check_val("r_rx_byte", 32'(rx_seen), 32'h3C);
        check_val("r_valid_cnt", 32'(valid_cnt), 32'd1);

        // tx_valid pulsed while busy is dropped
        clear_mon();
        miso_pat = 8'h00;
        send(4'hA);
        repeat (30) tick();
        send(4'h5);
        wait_idle("i_timeout");
        repeat (50) tick();
        check_val("i_accepts", 32'(n_accept), 32'd1);
        check_val("i_frames", 32'(n_ssfall), 32'd1);
        check_val("i_mosi", 32'(mosi_bits), 32'hA0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
